// File: rtl/btn_pkg.sv
// Shared definitions for the push-button reader: debounce FSM state encoding
// and the millisecond-to-clock-cycle conversion used to size its timers.
package btn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_HELD         = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } btn_state_t;

  // Never returns zero so a tiny clock or duration still yields a usable timer.
  function automatic int unsigned ms_to_cycles(input int unsigned clk_hz,
                                               input int unsigned ms);
    int unsigned cycles;
    cycles = (clk_hz / 32'd1000) * ms;
    if (cycles < 32'd1) begin
      return 32'd1;
    end else begin
      return cycles;
    end
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit; both stages reset to
// RST_VAL so the downstream logic sees a defined level out of reset.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_r;
  logic sync_r;

  // Metastability-hardening shift chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= RST_VAL;
      sync_r <= RST_VAL;
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/button_press_reader.sv
// Conditions one raw push-button pad into clean press/release/long-press events
// and keeps a wrapping count of accepted presses.
module button_press_reader
  import btn_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ    = 12000000,
  parameter int unsigned DEBOUNCE_MS    = 10,
  parameter int unsigned LONG_PRESS_MS  = 1000,
  parameter int unsigned COUNT_W        = 4,
  parameter bit          BTN_ACTIVE_LOW = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn,
  output logic               pressed,
  output logic               press_pulse,
  output logic               release_pulse,
  output logic               long_pulse,
  output logic               long_active,
  output logic [COUNT_W-1:0] press_count
);

  localparam int unsigned DB_CYCLES   = ms_to_cycles(CLK_FREQ_HZ, DEBOUNCE_MS);
  localparam int unsigned LONG_CYCLES = ms_to_cycles(CLK_FREQ_HZ, LONG_PRESS_MS);
  localparam int unsigned DB_W        = $clog2(DB_CYCLES + 32'd1);
  localparam int unsigned LONG_W      = $clog2(LONG_CYCLES + 32'd1);

  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 32'd1);
  localparam logic [LONG_W-1:0] LONG_MAX  = LONG_W'(LONG_CYCLES);
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 32'd1);

  btn_state_t          state_r;
  btn_state_t          state_s;
  logic                btn_act_s;
  logic                btn_sync_s;
  logic                db_done_s;

  logic [DB_W-1:0]     db_cnt_r;
  logic [DB_W-1:0]     db_cnt_s;
  logic [LONG_W-1:0]   hold_cnt_r;
  logic [LONG_W-1:0]   hold_cnt_s;
  logic [COUNT_W-1:0]  press_count_r;
  logic [COUNT_W-1:0]  press_count_s;
  logic                pressed_r;
  logic                pressed_s;
  logic                press_pulse_r;
  logic                press_pulse_s;
  logic                release_pulse_r;
  logic                release_pulse_s;
  logic                long_pulse_r;
  logic                long_pulse_s;
  logic                long_active_r;
  logic                long_active_s;
  logic                hold_step_s;

  // Normalise polarity so the synchroniser reset value is always "not pressed".
  assign btn_act_s = btn ^ BTN_ACTIVE_LOW;

  sync_2ff #(
    .RST_VAL(1'b0)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (btn_act_s),
    .q    (btn_sync_s)
  );

  assign db_done_s = (db_cnt_r == DB_LAST);

  // Debounce FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Debounce FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (btn_sync_s) state_s = ST_PRESS_WAIT;
        else            state_s = ST_IDLE;
      end
      ST_PRESS_WAIT: begin
        if (!btn_sync_s)     state_s = ST_IDLE;
        else if (db_done_s)  state_s = ST_HELD;
        else                 state_s = ST_PRESS_WAIT;
      end
      ST_HELD: begin
        if (btn_sync_s) state_s = ST_HELD;
        else            state_s = ST_RELEASE_WAIT;
      end
      ST_RELEASE_WAIT: begin
        if (btn_sync_s)      state_s = ST_HELD;
        else if (db_done_s)  state_s = ST_IDLE;
        else                 state_s = ST_RELEASE_WAIT;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Next values for timers, counter and registered event outputs.
  always_comb begin
    db_cnt_s        = db_cnt_r;
    hold_cnt_s      = hold_cnt_r;
    press_count_s   = press_count_r;
    press_pulse_s   = 1'b0;
    release_pulse_s = 1'b0;
    long_pulse_s    = 1'b0;
    long_active_s   = long_active_r;
    hold_step_s     = 1'b0;
    pressed_s       = (state_s == ST_HELD) || (state_s == ST_RELEASE_WAIT);

    case (state_r)
      ST_IDLE: begin
        db_cnt_s = '0;
      end
      ST_PRESS_WAIT: begin
        if (state_s == ST_HELD) begin
          db_cnt_s      = '0;
          hold_cnt_s    = '0;
          press_pulse_s = 1'b1;
          press_count_s = press_count_r + COUNT_W'(1'b1);
        end else begin
          db_cnt_s = db_cnt_r + DB_W'(1'b1);
        end
      end
      ST_HELD: begin
        db_cnt_s    = '0;
        hold_step_s = 1'b1;
      end
      ST_RELEASE_WAIT: begin
        // A release accepted on the threshold edge wins over the long event.
        if (state_s == ST_IDLE) begin
          db_cnt_s        = '0;
          release_pulse_s = 1'b1;
          long_active_s   = 1'b0;
        end else if (state_s == ST_HELD) begin
          db_cnt_s    = '0;
          hold_step_s = 1'b1;
        end else begin
          db_cnt_s    = db_cnt_r + DB_W'(1'b1);
          hold_step_s = 1'b1;
        end
      end
      default: begin
        db_cnt_s = '0;
      end
    endcase

    // Hold timer saturates, so long_pulse fires at most once per press.
    if (hold_step_s && (hold_cnt_r != LONG_MAX)) begin
      hold_cnt_s = hold_cnt_r + LONG_W'(1'b1);
      if (hold_cnt_r == LONG_LAST) begin
        long_pulse_s  = 1'b1;
        long_active_s = 1'b1;
      end else begin
        long_pulse_s  = 1'b0;
      end
    end else begin
      hold_cnt_s = hold_cnt_s;
    end
  end

  // Timers, press counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_cnt_r        <= '0;
      hold_cnt_r      <= '0;
      press_count_r   <= '0;
      pressed_r       <= 1'b0;
      press_pulse_r   <= 1'b0;
      release_pulse_r <= 1'b0;
      long_pulse_r    <= 1'b0;
      long_active_r   <= 1'b0;
    end else begin
      db_cnt_r        <= db_cnt_s;
      hold_cnt_r      <= hold_cnt_s;
      press_count_r   <= press_count_s;
      pressed_r       <= pressed_s;
      press_pulse_r   <= press_pulse_s;
      release_pulse_r <= release_pulse_s;
      long_pulse_r    <= long_pulse_s;
      long_active_r   <= long_active_s;
    end
  end

  assign pressed       = pressed_r;
  assign press_pulse   = press_pulse_r;
  assign release_pulse = release_pulse_r;
  assign long_pulse    = long_pulse_r;
  assign long_active   = long_active_r;
  assign press_count   = press_count_r;

endmodule

// File: tb/tb_button_press_reader.sv
// Directed bench for button_press_reader: an active-high and an active-low
// instance, with pulse events scoreboarded by the clock edge they must follow.
module tb_button_press_reader;

  localparam logic [5:0] A_PRESS = 6'b000001;
  localparam logic [5:0] A_REL   = 6'b000010;
  localparam logic [5:0] A_LONG  = 6'b000100;
  localparam logic [5:0] B_PRESS = 6'b001000;
  localparam logic [5:0] B_REL   = 6'b010000;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_a = 1'b0;
  logic       btn_b = 1'b1;

  logic       a_pressed, a_press_pulse, a_release_pulse, a_long_pulse, a_long_active;
  logic [3:0] a_press_count;
  logic       b_pressed, b_press_pulse, b_release_pulse, b_long_pulse, b_long_active;
  logic [3:0] b_press_count;

  int cyc      = 0;
  int checks   = 0;
  int failures = 0;
  int c        = 0;

  typedef struct {
    int         edge_n;
    logic [5:0] mask;
  } exp_t;
  exp_t sb[$];

  button_press_reader #(
    .CLK_FREQ_HZ(1000), .DEBOUNCE_MS(4), .LONG_PRESS_MS(10),
    .COUNT_W(4), .BTN_ACTIVE_LOW(1'b0)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .btn(btn_a),
    .pressed(a_pressed), .press_pulse(a_press_pulse),
    .release_pulse(a_release_pulse), .long_pulse(a_long_pulse),
    .long_active(a_long_active), .press_count(a_press_count)
  );

  button_press_reader #(
    .CLK_FREQ_HZ(1000), .DEBOUNCE_MS(4), .LONG_PRESS_MS(10),
    .COUNT_W(4), .BTN_ACTIVE_LOW(1'b1)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .btn(btn_b),
    .pressed(b_pressed), .press_pulse(b_press_pulse),
    .release_pulse(b_release_pulse), .long_pulse(b_long_pulse),
    .long_active(b_long_active), .press_count(b_press_count)
  );

  always #5 clk = ~clk;

  // Edge counter: at a negedge, cyc is the index of the preceding posedge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_ev(input int e, input logic [5:0] m);
    exp_t t;
    t.edge_n = e;
    t.mask   = m;
    sb.push_back(t);
  endtask

  // Advance to the next negedge and compare all pulse outputs with the scoreboard.
  task automatic tick();
    logic [5:0] obs;
    logic [5:0] expv;
    @(negedge clk);
    obs  = {1'b0, b_release_pulse, b_press_pulse, a_long_pulse, a_release_pulse, a_press_pulse};
    obs[5] = b_long_pulse;
    obs  = {obs[5], obs[4:0]};
    expv = 6'b000000;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].edge_n == cyc) begin
        expv = expv | sb[i].mask;
        sb.delete(i);
      end
    end
    check("pulses", {26'd0, obs}, {26'd0, expv});
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    #1;
    check("rst_a_outs", {a_pressed, a_press_pulse, a_release_pulse, a_long_pulse, a_long_active, a_press_count}, 32'd0);
    check("rst_b_outs", {b_pressed, b_press_pulse, b_release_pulse, b_long_pulse, b_long_active, b_press_count}, 32'd0);
    ticks(3);
    rst_n = 1'b1;
    ticks(5);

    // Clean hold through the long-press threshold, then clean release.
    c = cyc; btn_a = 1'b1;
    expect_ev(c + 7, A_PRESS);
    expect_ev(c + 17, A_LONG);
    ticks(6);  check("s1_pressed_before", a_pressed, 32'd0);
    ticks(1);  check("s1_pressed", a_pressed, 32'd1);
    check("s1_count", a_press_count, 32'd1);
    ticks(9);  check("s1_long_active_before", a_long_active, 32'd0);
    ticks(1);  check("s1_long_active", a_long_active, 32'd1);
    ticks(13);
    c = cyc; btn_a = 1'b0;
    expect_ev(c + 7, A_REL);
    ticks(6);  check("s1_pressed_rel_before", a_pressed, 32'd1);
    ticks(1);  check("s1_pressed_rel", a_pressed, 32'd0);
    check("s1_long_active_cleared", a_long_active, 32'd0);
    ticks(3);

    // Bounce: never stable long enough to be accepted.
    for (int n = 0; n < 10; n++) begin
      btn_a = 1'b1; ticks(2);
      btn_a = 1'b0; ticks(1);
    end
    ticks(8);
    check("s2_pressed", a_pressed, 32'd0);
    check("s2_count", a_press_count, 32'd1);

    // Release glitch while held; hold timer keeps running across it.
    c = cyc; btn_a = 1'b1;
    expect_ev(c + 7, A_PRESS);
    expect_ev(c + 17, A_LONG);
    ticks(12);
    btn_a = 1'b0; ticks(2);
    btn_a = 1'b1; ticks(10);
    check("s3_pressed", a_pressed, 32'd1);
    check("s3_count", a_press_count, 32'd2);
    check("s3_long_active", a_long_active, 32'd1);
    c = cyc; btn_a = 1'b0;
    expect_ev(c + 7, A_REL);
    ticks(10);
    check("s3_long_active_cleared", a_long_active, 32'd0);
    check("s3_pressed_rel", a_pressed, 32'd0);

    // Counter wrap from a fresh reset.
    rst_n = 1'b0; ticks(2);
    rst_n = 1'b1; ticks(2);
    for (int n = 1; n <= 17; n++) begin
      c = cyc; btn_a = 1'b1;
      expect_ev(c + 7, A_PRESS);
      ticks(8);
      check("s4_count", a_press_count, n % 16);
      c = cyc; btn_a = 1'b0;
      expect_ev(c + 7, A_REL);
      ticks(8);
    end

    // Reset mid-hold, button still held afterwards.
    c = cyc; btn_a = 1'b1;
    expect_ev(c + 7, A_PRESS);
    ticks(10);
    check("s5_count_before_rst", a_press_count, 32'd2);
    rst_n = 1'b0;
    #1;
    check("s5_rst_outs", {a_pressed, a_press_pulse, a_release_pulse, a_long_pulse, a_long_active, a_press_count}, 32'd0);
    ticks(2);
    rst_n = 1'b1;
    c = cyc;
    expect_ev(c + 7, A_PRESS);
    ticks(6);  check("s5_count_before", a_press_count, 32'd0);
    ticks(1);  check("s5_count", a_press_count, 32'd1);
    check("s5_pressed", a_pressed, 32'd1);
    c = cyc; btn_a = 1'b0;
    expect_ev(c + 7, A_REL);
    ticks(10);

    // Active-low pad: idle high must stay quiet, low is a press.
    ticks(50);
    check("s6_idle_pressed", b_pressed, 32'd0);
    check("s6_idle_count", b_press_count, 32'd0);
    c = cyc; btn_b = 1'b0;
    expect_ev(c + 7, B_PRESS);
    ticks(6);  check("s6_pressed_before", b_pressed, 32'd0);
    ticks(1);  check("s6_pressed", b_pressed, 32'd1);
    check("s6_count", b_press_count, 32'd1);
    ticks(3);
    c = cyc; btn_b = 1'b1;
    expect_ev(c + 7, B_REL);
    ticks(10);
    check("s6_pressed_rel", b_pressed, 32'd0);

    check("sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
